// File: rtl/wb_mux_arbiter.sv
// N-master to 1-slave Wishbone classic arbiter/multiplexer with fixed-priority or
// round-robin selection, CYC-based bus lock and a per-transfer STB timeout.
module wb_mux_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int RR_MODE     = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS*AW-1:0]   m_addr_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_wdata_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    output logic [NUM_MASTERS*DW-1:0]   m_rdata_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic                        s_we_o,
    output logic [AW-1:0]               s_addr_o,
    output logic [DW-1:0]               s_wdata_o,
    output logic [DW/8-1:0]             s_sel_o,
    input  logic [DW-1:0]               s_rdata_i,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,
    output logic [NUM_MASTERS-1:0]      grant_o,
    output logic                        busy_o
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW = DW / 8;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                 state_reg, state_next;
    logic [NUM_MASTERS-1:0] grant_reg, grant_next;
    logic [IW-1:0]          gidx_reg, gidx_next;
    logic [IW-1:0]          ptr_reg, ptr_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic [NUM_MASTERS-1:0] req;
    logic [IW-1:0]          win_idx;
    logic [IW-1:0]          low_any;
    logic [IW-1:0]          low_hi;
    logic                   found_hi;
    logic                   tmo;

    assign req = m_cyc_i & m_stb_i;

    // Descending scans leave the lowest requester overall and the lowest one at/above the pointer.
    always_comb begin
        low_any  = '0;
        low_hi   = '0;
        found_hi = 1'b0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (req[k]) begin
                low_any = IW'(k);
                if (IW'(k) >= ptr_reg) begin
                    low_hi   = IW'(k);
                    found_hi = 1'b1;
                end
            end
        end
        win_idx = (RR_MODE != 0 && found_hi) ? low_hi : low_any;
    end

    // Slave side follows the granted master combinationally; all zero while idle.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        s_sel_o   = '0;
        if (state_reg == GRANT) begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                if (gidx_reg == IW'(k)) begin
                    s_cyc_o   = m_cyc_i[k];
                    s_stb_o   = m_stb_i[k];
                    s_we_o    = m_we_i[k];
                    s_addr_o  = m_addr_i[k*AW +: AW];
                    s_wdata_o = m_wdata_i[k*DW +: DW];
                    s_sel_o   = m_sel_i[k*SW +: SW];
                end
            end
        end
    end

    // A coinciding slave ACK or ERR pre-empts the synthetic error.
    assign tmo = (TIMEOUT != 0) && s_stb_o && !s_ack_i && !s_err_i && (cnt_reg == TMO_LAST);

    always_comb begin
        cnt_next = cnt_reg + CW'(1);
        if (TIMEOUT == 0 || !s_stb_o || s_ack_i || s_err_i || tmo) begin
            cnt_next = '0;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_route
            assign m_rdata_o[gi*DW +: DW] = s_rdata_i;
            assign m_ack_o[gi] = grant_reg[gi] & s_ack_i & s_stb_o;
            assign m_err_o[gi] = grant_reg[gi] & (s_err_i | tmo) & s_stb_o;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        gidx_next  = gidx_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next = GRANT;
                    gidx_next  = win_idx;
                    for (int k = 0; k < NUM_MASTERS; k++) begin
                        grant_next[k] = (win_idx == IW'(k));
                    end
                end
            end
            GRANT: begin
                // Bus stays locked until the owner releases CYC.
                if (!s_cyc_o) begin
                    state_next = IDLE;
                    grant_next = '0;
                    if (RR_MODE != 0) begin
                        ptr_next = (gidx_reg == IW'(NUM_MASTERS - 1)) ? '0 : gidx_reg + IW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            gidx_reg  <= '0;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            gidx_reg  <= gidx_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign grant_o = grant_reg;
    assign busy_o  = (state_reg == GRANT);

endmodule
